seg_display_arbiter: RTL



---
 rtl/seg_pkg.sv | 41 ++++
 rtl/rr_picker.sv | 38 +++
 rtl/seg_display_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// ============================================================================
// Module  : seg_pkg
// Brief   : Shared constants, glyph table and helpers for the seven-segment
//           display arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package seg_pkg;

  // Digits on the physical display; one byte of segment frame per digit.
  localparam int SEG_DIGITS = 8;

  // All segments and the decimal point off.
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Hex glyphs, entry n at bits [8n+7:8n]; bit7 (DP) is always clear here.
  localparam logic [127:0] SEG_HEX_GLYPHS = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h67, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  // Arbiter states.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } arb_state_e;

  // Width of a client index; at least one bit even for a single client.
  function automatic int client_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Segment pattern for one hex nibble.
  function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
    return SEG_HEX_GLYPHS[{nib, 3'b000} +: 8];
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module  : rr_picker
// Brief   : Combinational round-robin search. Returns the first requester
//           found cyclically starting just after the pointer, as a one-hot
//           vector, plus a flag saying whether anyone requested at all.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_picker #(
  parameter int NUM_CLIENTS = 4,
  parameter int IDX_W       = 2
) (
  input  logic [NUM_CLIENTS-1:0] req_i,
  input  logic [IDX_W-1:0]       ptr_i,
  output logic [NUM_CLIENTS-1:0] win_o,
  output logic                   valid_o
);

  // Walk ptr+1, ptr+2, ... wrapping; the pointer itself is visited last so
  // the current holder only wins again when nobody else is asking.
  always_comb begin
    logic [IDX_W-1:0] idx;
    win_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int off = 1; off <= NUM_CLIENTS; off++) begin
      idx = IDX_W'((int'(ptr_i) + off) % NUM_CLIENTS);
      if (!valid_o && req_i[idx]) begin
        win_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg_display_arbiter.sv
// ============================================================================
// Module  : seg_display_arbiter
// Brief   : Shares one 8-digit seven-segment display among NUM_CLIENTS
//           requesters with round-robin grants, a minimum dwell per grant
//           and an optional per-client lock. The granted client's 32-bit
//           value is hex-decoded into a registered 64-bit segment frame.
//           Optional macro SEG_ARB_CLIENT_DP_EN lights the decimal point of
//           the digit whose index equals the granted client.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int NUM_CLIENTS  = 4,
  parameter int DWELL_CYCLES = 50000000,
  parameter int VAL_W        = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CLIENTS-1:0]       req,
  input  logic [NUM_CLIENTS-1:0]       lock,
  input  logic [NUM_CLIENTS*VAL_W-1:0] value,
  output logic [NUM_CLIENTS-1:0]       grant,
  output logic [63:0]                  segments,
  output logic                         active
);

  localparam int IDX_W = client_idx_w(NUM_CLIENTS);
  localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  arb_state_e             state_q;
  logic [NUM_CLIENTS-1:0] grant_q;
  logic [IDX_W-1:0]       ptr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [63:0]            segments_q;
  logic [63:0]            segments_d;

  logic [NUM_CLIENTS-1:0] win;
  logic                   win_valid;
  logic [IDX_W-1:0]       win_idx;
  logic                   req_g;
  logic                   lock_g;
  logic [VAL_W-1:0]       sel_value;

  rr_picker #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IDX_W       (IDX_W)
  ) u_rr_picker (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .win_o   (win),
    .valid_o (win_valid)
  );

  // Holder's own request / lock; both zero when nothing is granted.
  assign req_g  = |(req & grant_q);
  assign lock_g = |(lock & grant_q);

  // Binary index of the round-robin winner, used to move the pointer.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (win[i]) win_idx = IDX_W'(i);
    end
  end

  // Value of the currently granted client (grant is one-hot or zero).
  always_comb begin
    sel_value = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (grant_q[i]) sel_value = sel_value | value[i*VAL_W +: VAL_W];
    end
  end

  // Next segment frame: decode each nibble, blank when idle, set or clear DP.
  always_comb begin
    segments_d = {SEG_DIGITS{SEG_BLANK}};
    if (|grant_q) begin
      for (int k = 0; k < SEG_DIGITS; k++) begin
        segments_d[8*k +: 8] = hex_glyph(sel_value[4*k +: 4]);
`ifdef SEG_ARB_CLIENT_DP_EN
        // The pointer always names the current holder while in SHOW.
        if (k == int'(ptr_q)) segments_d[8*k+7] = 1'b1;
`else
        segments_d[8*k+7] = 1'b0;
`endif
      end
    end
  end

  // Arbitration FSM: grant, round-robin pointer and dwell counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= IDX_W'(NUM_CLIENTS - 1);
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (win_valid) begin
            state_q <= ST_SHOW;
            grant_q <= win;
            ptr_q   <= win_idx;
          end
        end
        ST_SHOW: begin
          if (!req_g) begin
            // Holder let go (takes priority over a coincident expiry):
            // hand over without a blank cycle, or fall idle.
            cnt_q <= '0;
            if (win_valid) begin
              grant_q <= win;
              ptr_q   <= win_idx;
            end else begin
              state_q <= ST_IDLE;
              grant_q <= '0;
            end
          end else if (cnt_q == CNT_LAST) begin
            // Dwell expired. The picker visits the holder last, so without
            // a lock it yields to any other requester or re-picks the holder.
            cnt_q <= '0;
            if (!lock_g) begin
              grant_q <= win;
              ptr_q   <= win_idx;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Segment frame register: one clock behind the grant and the live value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) segments_q <= '0;
    else        segments_q <= segments_d;
  end

  assign grant    = grant_q;
  assign segments = segments_q;
  assign active   = |grant_q;

endmodule

`default_nettype wire
